// File: rtl/asic_function_sequencer.sv
// asic_function_sequencer: round-robin sharing of one ASIC nonlinear-function port between two requesters.
module asic_function_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 8,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   req0_valid,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  output logic                   req1_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_id,
  output logic [DATA_WIDTH-1:0]  asic_data_out,
  output logic                   asic_start,
  input  logic [DATA_WIDTH-1:0]  asic_data_in,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] done_count
);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CAPTURE, RESPOND} state_t;
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  state_t state, state_nxt;
  logic last_grant, grant_id, grant, pick1;
  logic [7:0] cnt;
  always_comb begin
    pick1 = req1_valid && (!req0_valid || !last_grant);
    grant = (state == IDLE) && enable && (req0_valid || req1_valid);
    state_nxt = state == IDLE    ? (grant ? DRIVE : IDLE) :
                state == DRIVE   ? SETTLE :
                state == SETTLE  ? (cnt == 8'd0 ? CAPTURE : SETTLE) :
                state == CAPTURE ? RESPOND :
                state == RESPOND ? (rsp_ready ? IDLE : RESPOND) : IDLE;
  end
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant && pick1;
  assign asic_start = state == DRIVE;
  assign busy       = state != IDLE;
  assign rsp_valid  = state == RESPOND;
  always_ff @(posedge S_AXI_ACLK)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  // operand is sampled only on the grant edge and left in place after completion
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      asic_data_out <= '0;
      rsp_data      <= '0;
      rsp_id        <= 1'b0;
      done_count    <= '0;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      cnt           <= 8'd0;
    end else begin
      if (grant) begin
        asic_data_out <= pick1 ? req1_data : req0_data;
        grant_id      <= pick1;
      end
      if (state == DRIVE) cnt <= SETTLE_LOAD;
      else if (state == SETTLE && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == CAPTURE) begin
        rsp_data <= asic_data_in;
        rsp_id   <= grant_id;
      end
      if (rsp_valid && rsp_ready) begin
        last_grant <= grant_id;
        done_count <= done_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_asic_function_sequencer.sv
// tb_asic_function_sequencer: directed and randomized transactions checked against a transaction-level model.
module tb_asic_function_sequencer;
  localparam int DW = 32;
  localparam int SC = 8;
  localparam int CW = 4;
  logic S_AXI_ACLK = 1'b0;
  logic rst = 1'b1, enable = 1'b0, rsp_ready = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DW-1:0] req0_data = '0, req1_data = '0, asic_data_in = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, asic_start, busy;
  logic [DW-1:0] rsp_data, asic_data_out;
  logic [CW-1:0] done_count;
  int total = 0, passed = 0;
  int m_last = 1, m_done = 0;

  asic_function_sequencer #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC), .COUNT_WIDTH(CW)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .rst(rst), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .asic_data_out(asic_data_out), .asic_start(asic_start), .asic_data_in(asic_data_in),
    .busy(busy), .done_count(done_count)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic scramble_reqs();
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_data  = $urandom;
    req1_data  = $urandom;
  endtask

  // one complete request: grant, start pulse, settle, capture, optional stall, handshake
  task automatic txn(input logic v0, input logic v1, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                     input logic [DW-1:0] res, input int stall, input bit drop_en, input bit b2b);
    logic g;
    logic [DW-1:0] op;
    @(negedge S_AXI_ACLK);
    enable = 1'b1; rsp_ready = 1'b0;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1;
    #1;
    g  = (v0 && v1) ? (m_last == 0) : v1;
    op = g ? d1 : d0;
    chk("grant_ready0", req0_ready, !g);
    chk("grant_ready1", req1_ready, g);
    chk("grant_busy", busy, 0);
    for (int k = 1; k <= SC + 2; k++) begin
      @(negedge S_AXI_ACLK);
      if (drop_en && k >= 2) enable = 1'b0;
      scramble_reqs();
      asic_data_in = (k == SC + 2) ? res : $urandom;
      #1;
      chk("asic_start", asic_start, k == 1);
      chk("busy_op", busy, 1);
      chk("rsp_early", rsp_valid, 0);
      chk("op_hold", asic_data_out, op);
      chk("ready0_busy", req0_ready, 0);
      chk("ready1_busy", req1_ready, 0);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge S_AXI_ACLK);
      rsp_ready = (s == stall);
      scramble_reqs();
      asic_data_in = $urandom;
      #1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, res);
      chk("rsp_id", rsp_id, g);
      chk("ready0_rsp", req0_ready, 0);
      chk("ready1_rsp", req1_ready, 0);
      chk("done_hold", done_count, DW'(m_done % 16));
    end
    m_last = g;
    m_done++;
    if (!b2b) begin
      @(negedge S_AXI_ACLK);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      chk("post_busy", busy, 0);
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_op_kept", asic_data_out, op);
      chk("post_done", done_count, DW'(m_done % 16));
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    int r;
    repeat (2) @(negedge S_AXI_ACLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_start", asic_start, 0);
    chk("rst_op", asic_data_out, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_done", done_count, 0);
    rst = 1'b0;
    txn(1, 0, 32'h0000_1234, 32'h0, 32'h0000_ABCD, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      txn(1, 1, 32'h11, 32'h22, $urandom, 0, 0, 1);
    txn(0, 1, 32'h0, $urandom, $urandom, 20, 0, 0);
    @(negedge S_AXI_ACLK);
    enable = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge S_AXI_ACLK);
      #1;
      chk("gate_ready0", req0_ready, 0);
      chk("gate_busy", busy, 0);
    end
    txn(1, 0, $urandom, 32'h0, $urandom, 1, 1, 0);
    enable = 1'b0; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge S_AXI_ACLK);
      #1;
      chk("drop_no_grant", req0_ready, 0);
      chk("drop_busy", busy, 0);
    end
    @(negedge S_AXI_ACLK);
    enable = 1'b1; req0_valid = 1'b1; req1_valid = 1'b0; req0_data = $urandom;
    #1;
    chk("rstop_grant", req0_ready, 1);
    repeat (4) @(negedge S_AXI_ACLK);
    rst = 1'b1; req0_valid = 1'b0;
    @(negedge S_AXI_ACLK);
    rst = 1'b0;
    #1;
    m_last = 1; m_done = 0;
    chk("rstop_busy", busy, 0);
    chk("rstop_rsp_valid", rsp_valid, 0);
    chk("rstop_op", asic_data_out, 0);
    chk("rstop_done", done_count, 0);
    chk("rstop_rsp_id", rsp_id, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge S_AXI_ACLK);
      #1;
      chk("rstop_no_rsp", rsp_valid, 0);
    end
    txn(1, 1, $urandom, $urandom, $urandom, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(1, 3);
      d = $urandom;
      txn(r[0], r[1], d, ~d, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge S_AXI_ACLK);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("done_wrap", done_count, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
